slave_bus_bridge: RTL and testbench

SLAVE_BUS_BRIDGE -- requirements
Module: slave_bus_bridge

---
 rtl/slave_bridge_pkg.sv | 19 +
 rtl/slave_bus_bridge_if.sv | 30 +++
 rtl/slave_bus_bridge_sync2.sv | 26 ++
 rtl/slave_bus_bridge.sv | 125 ++++++++++++
 tb/tb_slave_bus_bridge.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/slave_bridge_pkg.sv
// Shared types and defaults for the CPU-to-slave handshake bridge.
package slave_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_ACK,
    ST_ACK,
    ST_RELEASE
  } state_t;

  localparam int unsigned DEF_IRQ_LEN = 20;
  localparam int unsigned DEF_TIMEOUT = 4096;

  function automatic logic [7:0] pick_byte(input logic uds, input logic [15:0] din);
    return uds ? din[15:8] : din[7:0];
  endfunction

endpackage

// File: rtl/slave_bus_bridge_if.sv
// CPU bus plus slave-port signals of the bridge; the bridge uses the slave view.
interface slave_bus_bridge_if;

  logic        cs;
  logic        uds;
  logic        lds;
  logic        write_strobe;
  logic [1:0]  address;
  logic [15:0] din;
  logic [15:0] dout;
  logic        bus_ack;
  logic        bus_err;
  logic [7:0]  to_slave;
  logic [7:0]  from_slave;
  logic [1:0]  sel;
  logic        rd_n;
  logic        slave_irq;
  logic        dtack_n;

  modport master (
    output cs, uds, lds, write_strobe, address, din, from_slave, dtack_n,
    input  dout, bus_ack, bus_err, to_slave, sel, rd_n, slave_irq
  );

  modport slave (
    input  cs, uds, lds, write_strobe, address, din, from_slave, dtack_n,
    output dout, bus_ack, bus_err, to_slave, sel, rd_n, slave_irq
  );

endinterface

// File: rtl/slave_bus_bridge_sync2.sv
// Two-flop synchronizer for the slave acknowledge line.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/slave_bus_bridge.sv
// Bridges one CPU access to the slave port: IRQ pulse, wait for acknowledge, timeout abort.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   IDLE       | waiting for cs with a byte strobe
//   REQ        | slave_irq high for IRQ_LEN cycles, acks ignored
//   WAIT_ACK   | waiting for synchronized dtack_n rising edge
//   ACK        | bus_ack pulse
//   RELEASE    | waiting for cs to drop before the next access
module slave_bus_bridge
  import slave_bridge_pkg::*;
#(
  parameter int unsigned IRQ_LEN = DEF_IRQ_LEN,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input logic              clk,
  input logic              reset_n,
  slave_bus_bridge_if.slave bus
);

  localparam logic [7:0]  IRQ_LOAD = 8'(IRQ_LEN - 1);
  localparam logic [15:0] TO_LOAD  = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_irq_cnt;
  logic [15:0] r_to_cnt;
  logic [15:0] r_dout;
  logic [7:0]  r_to_slave;
  logic [1:0]  r_sel;
  logic        r_rd_n;
  logic        r_irq;
  logic        r_ack;
  logic        r_err;
  logic        r_dtack_prev;
  logic        w_dtack_sync;
  logic        w_ack_edge;

  sync2 #(.RST_VAL(1'b1)) u_sync2 (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (bus.dtack_n),
    .o_q     (w_dtack_sync)
  );

  // The edge history runs in every state so an ack seen during REQ is consumed, not deferred.
  assign w_ack_edge = w_dtack_sync & ~r_dtack_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_irq_cnt    <= '0;
      r_to_cnt     <= '0;
      r_dout       <= '0;
      r_to_slave   <= '0;
      r_sel        <= '0;
      r_rd_n       <= 1'b1;
      r_irq        <= 1'b0;
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
      r_dtack_prev <= 1'b1;
    end else begin
      r_dtack_prev <= w_dtack_sync;
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.cs && (bus.uds || bus.lds)) begin
            r_to_slave <= pick_byte(bus.uds, bus.din);
            r_sel      <= bus.address;
            r_rd_n     <= bus.write_strobe;
            r_irq      <= 1'b1;
            r_irq_cnt  <= IRQ_LOAD;
            r_to_cnt   <= TO_LOAD;
            r_state    <= ST_REQ;
          end
        end
        ST_REQ, ST_WAIT_ACK: begin
          if (!bus.cs) begin
            r_irq     <= 1'b0;
            r_irq_cnt <= '0;
            r_to_cnt  <= '0;
            r_state   <= ST_IDLE;
          end else if (r_state == ST_WAIT_ACK && w_ack_edge) begin
            // Ack is checked before the timeout so a same-cycle tie completes normally.
            r_ack    <= 1'b1;
            r_to_cnt <= '0;
            if (!r_rd_n) r_dout <= {bus.from_slave, bus.from_slave};
            r_state  <= ST_ACK;
          end else if (r_to_cnt == '0) begin
            r_err     <= 1'b1;
            r_irq     <= 1'b0;
            r_irq_cnt <= '0;
            r_state   <= ST_RELEASE;
          end else begin
            r_to_cnt <= r_to_cnt - 16'd1;
            if (r_state == ST_REQ) begin
              if (r_irq_cnt == '0) begin
                r_irq   <= 1'b0;
                r_state <= ST_WAIT_ACK;
              end else begin
                r_irq_cnt <= r_irq_cnt - 8'd1;
              end
            end
          end
        end
        ST_ACK: begin
          r_state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!bus.cs) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.dout      = r_dout;
  assign bus.to_slave  = r_to_slave;
  assign bus.sel       = r_sel;
  assign bus.rd_n      = r_rd_n;
  assign bus.slave_irq = r_irq;
  assign bus.bus_ack   = r_ack;
  assign bus.bus_err   = r_err;

endmodule

// File: tb/tb_slave_bus_bridge.sv
// Scoreboard bench for slave_bus_bridge: driver queues expected responses, monitor checks them.
module tb_slave_bus_bridge;

  localparam int unsigned IRQ_LEN = 20;
  localparam int unsigned TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  slave_bus_bridge_if bus ();

  slave_bus_bridge #(.IRQ_LEN(IRQ_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic [15:0] dout;
    logic [7:0]  to_slave;
    logic [1:0]  sel;
    logic        rd_n;
  } resp_t;

  resp_t       exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int unsigned mon_req_cyc = 0;
  logic        mon_prev_irq = 1'b0;
  logic [15:0] model_dout = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    resp_t r;
    if (bus.slave_irq && !mon_prev_irq) mon_req_cyc = cyc;
    mon_prev_irq = bus.slave_irq;
    if (bus.bus_ack || bus.bus_err) begin
      check("ack_err_exclusive", 32'(bus.bus_ack & bus.bus_err), 32'd0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_response: got ack=%0b err=%0b, expected no response", bus.bus_ack, bus.bus_err);
      end else begin
        r = exp_q.pop_front();
        check("resp_is_err", 32'(bus.bus_err), 32'(r.is_err));
        check("resp_dout", 32'(bus.dout), 32'(r.dout));
        check("resp_to_slave", 32'(bus.to_slave), 32'(r.to_slave));
        check("resp_sel", 32'(bus.sel), 32'(r.sel));
        check("resp_rd_n", 32'(bus.rd_n), 32'(r.rd_n));
        if (r.is_err) check("timeout_latency", cyc - mon_req_cyc, TIMEOUT);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"}, 32'(bus.dout), 32'd0);
    check({tag, "_to_slave"}, 32'(bus.to_slave), 32'd0);
    check({tag, "_sel"}, 32'(bus.sel), 32'd0);
    check({tag, "_rd_n"}, 32'(bus.rd_n), 32'd1);
    check({tag, "_irq"}, 32'(bus.slave_irq), 32'd0);
    check({tag, "_ack"}, 32'(bus.bus_ack), 32'd0);
    check({tag, "_err"}, 32'(bus.bus_err), 32'd0);
  endtask

  // mode 0: ack dly cycles after irq ends; 1: no ack; 2: ack only during REQ; 3: drop cs dly cycles in
  task automatic access(input logic wr, input logic u, input logic l, input logic [1:0] a,
                        input logic [15:0] d, input logic [7:0] fs, input int mode,
                        input int dly, input int hold);
    resp_t e;
    int    w;
    int    irq_end;
    bit    done;
    bit    started;
    @(negedge clk);
    bus.cs = 1'b1; bus.uds = u; bus.lds = l; bus.write_strobe = wr;
    bus.address = a; bus.din = d; bus.from_slave = fs;
    if (mode != 3) begin
      e.is_err   = (mode != 0);
      e.to_slave = u ? d[15:8] : d[7:0];
      e.sel      = a;
      e.rd_n     = wr;
      if (mode == 0 && !wr) model_dout = {fs, fs};
      e.dout     = model_dout;
      exp_q.push_back(e);
    end
    started = 1'b0;
    for (int i = 0; i < 4 && !started; i++) begin
      @(negedge clk);
      started = bus.slave_irq;
    end
    check("irq_start", 32'(started), 32'd1);
    bus.din = 16'($urandom);
    w = 0; irq_end = -1; done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.slave_irq) w++;
      else if (irq_end < 0) irq_end = k;
      if (mode == 0 && irq_end >= 0 && k == irq_end + dly) bus.dtack_n = 1'b0;
      if (mode == 0 && irq_end >= 0 && k == irq_end + dly + 2) bus.dtack_n = 1'b1;
      if (mode == 2 && k == 2) bus.dtack_n = 1'b0;
      if (mode == 2 && k == 4) bus.dtack_n = 1'b1;
      if (mode == 3 && k == dly) begin
        bus.cs = 1'b0;
        @(negedge clk);
        check("abort_irq_low", 32'(bus.slave_irq), 32'd0);
        done = 1'b1;
      end else if (bus.bus_ack || bus.bus_err) begin
        done = 1'b1;
      end
    end
    bus.dtack_n = 1'b1;
    if (mode != 3) begin
      check("response_seen", 32'(done), 32'd1);
      check("irq_width", 32'(w), IRQ_LEN);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("no_reaccess", 32'(bus.slave_irq), 32'd0);
    end
    bus.cs = 1'b0; bus.uds = 1'b0; bus.lds = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [1:0] s;
    int         m;
    bit         seen_hi;
    bit         fell;
    bus.cs = 1'b0; bus.uds = 1'b0; bus.lds = 1'b0; bus.write_strobe = 1'b0;
    bus.address = '0; bus.din = '0; bus.from_slave = '0; bus.dtack_n = 1'b1;
    #12;
    check_reset_outputs("rst_init");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    access(1'b1, 1'b1, 1'b0, 2'd2, 16'hA55A, 8'h00, 0, 5, 0);
    access(1'b0, 1'b0, 1'b1, 2'd1, 16'h1234, 8'h3C, 0, 3, 0);
    access(1'b0, 1'b1, 1'b1, 2'd3, 16'h0F0F, 8'h77, 1, 0, 0);
    access(1'b1, 1'b0, 1'b1, 2'd0, 16'hBEEF, 8'h11, 2, 0, 0);
    access(1'b1, 1'b0, 1'b1, 2'd1, 16'hC3D4, 8'h22, 0, 0, 10);
    access(1'b0, 1'b1, 1'b0, 2'd2, 16'h5678, 8'h99, 3, 5, 3);
    access(1'b0, 1'b1, 1'b0, 2'd3, 16'h9ABC, 8'h88, 3, 30, 0);

    for (int t = 0; t < 40; t++) begin
      s = 2'($urandom_range(1, 3));
      m = int'($urandom_range(0, 9));
      if (m == 6) m = 1;
      else if (m == 7) m = 2;
      else if (m == 8) m = 3;
      else m = 0;
      access(1'($urandom_range(0, 1)), s[1], s[0], 2'($urandom_range(0, 3)), 16'($urandom),
             8'($urandom), m, (m == 3) ? int'($urandom_range(1, 50)) : int'($urandom_range(0, 30)),
             int'($urandom_range(0, 10)));
    end

    // Make sure dout is nonzero so the mid-access reset visibly clears it.
    access(1'b0, 1'b0, 1'b1, 2'd1, 16'h0000, 8'h5A, 0, 2, 0);

    @(negedge clk);
    bus.cs = 1'b1; bus.uds = 1'b1; bus.lds = 1'b0; bus.write_strobe = 1'b0;
    bus.address = 2'd3; bus.din = 16'hFACE; bus.from_slave = 8'hE1;
    seen_hi = 1'b0; fell = 1'b0;
    for (int i = 0; i < 60 && !fell; i++) begin
      @(negedge clk);
      if (bus.slave_irq) seen_hi = 1'b1;
      else if (seen_hi) fell = 1'b1;
    end
    check("rst_reach_wait_ack", 32'(fell), 32'd1);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    bus.cs = 1'b0; bus.uds = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    model_dout = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_post_irq", 32'(bus.slave_irq), 32'd0);

    access(1'b1, 1'b1, 1'b0, 2'd1, 16'h6B00, 8'h00, 0, 4, 0);
    access(1'b0, 1'b0, 1'b1, 2'd2, 16'h0000, 8'hD2, 0, 7, 0);

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
